// File: rtl/fft_sdf_stage4.sv
// Radix-2 SDF stage 4 of the 32-point DIF FFT: 2-deep feedback delay, add/sub butterfly
// and W4 twiddle, with an input register for stage-3 timing and a registered 17-bit output.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no group in flight; a valid sample is taken as WAITING k=0
// WAITING | filling the delay line with the first half of a fresh group
// FIRST   | second half arriving: emit sums, store differences
// SECOND  | emit stored differences (x1 / x-j), store next group's first half
// DRAIN   | input stopped after SECOND k=0: emit the last difference
module fft_sdf_stage4 (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic signed [15:0] in_r,
    input  logic signed [15:0] in_i,
    output logic               out_valid,
    output logic signed [16:0] out_r,
    output logic signed [16:0] out_i,
    output logic [4:0]         out_idx,
    output logic               err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAITING = 3'd1,
        FIRST   = 3'd2,
        SECOND  = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic signed [15:0] x_r_q, x_i_q;
    logic               v_q;
    logic signed [16:0] sr_r [2];
    logic signed [16:0] sr_i [2];
    logic               k, k_nxt;
    logic [4:0]         idx_cnt;

    logic signed [16:0] xe_r, xe_i, b_r, b_i, w4_r, w4_i;
    logic               emit, shift, clr_sr, set_err;
    logic signed [16:0] emit_r, emit_i, push_r, push_i;

    assign xe_r = {x_r_q[15], x_r_q};
    assign xe_i = {x_i_q[15], x_i_q};
    assign b_r  = sr_r[0];
    assign b_i  = sr_i[0];

    // W4^k: k=0 passes through, k=1 multiplies by -j.
    assign w4_r = k ? b_i : b_r;
    assign w4_i = k ? -b_r : b_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (v_q) state_nxt = WAITING;
            end
            WAITING: begin
                if (v_q && k) state_nxt = FIRST;
            end
            FIRST: begin
                if (v_q && k) state_nxt = SECOND;
            end
            SECOND: begin
                if (v_q) begin
                    if (k) state_nxt = FIRST;
                end else begin
                    state_nxt = k ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = v_q ? WAITING : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        emit    = 1'b0;
        emit_r  = '0;
        emit_i  = '0;
        shift   = 1'b0;
        push_r  = '0;
        push_i  = '0;
        clr_sr  = 1'b0;
        set_err = 1'b0;
        k_nxt   = k;
        case (state)
            IDLE, WAITING: begin
                if (v_q) begin
                    shift  = 1'b1;
                    push_r = xe_r;
                    push_i = xe_i;
                    k_nxt  = ~k;
                end
            end
            FIRST: begin
                if (v_q) begin
                    emit   = 1'b1;
                    emit_r = b_r + xe_r;
                    emit_i = b_i + xe_i;
                    shift  = 1'b1;
                    push_r = b_r - xe_r;
                    push_i = b_i - xe_i;
                    k_nxt  = ~k;
                end
            end
            SECOND: begin
                emit   = 1'b1;
                emit_r = w4_r;
                emit_i = w4_i;
                if (v_q) begin
                    shift  = 1'b1;
                    push_r = xe_r;
                    push_i = xe_i;
                    k_nxt  = ~k;
                end else if (!k) begin
                    shift = 1'b1;
                    k_nxt = 1'b1;
                end else begin
                    // Half of the next group is already stored and cannot be completed.
                    clr_sr  = 1'b1;
                    set_err = 1'b1;
                    k_nxt   = 1'b0;
                end
            end
            DRAIN: begin
                emit   = 1'b1;
                emit_r = w4_r;
                emit_i = w4_i;
                shift  = 1'b1;
                if (v_q) begin
                    push_r = xe_r;
                    push_i = xe_i;
                    k_nxt  = 1'b1;
                end else begin
                    k_nxt = 1'b0;
                end
            end
            default: begin
                clr_sr = 1'b1;
                k_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_r_q     <= '0;
            x_i_q     <= '0;
            v_q       <= 1'b0;
            sr_r[0]   <= '0;
            sr_r[1]   <= '0;
            sr_i[0]   <= '0;
            sr_i[1]   <= '0;
            k         <= 1'b0;
            idx_cnt   <= '0;
            out_valid <= 1'b0;
            out_r     <= '0;
            out_i     <= '0;
            out_idx   <= '0;
            err       <= 1'b0;
        end else begin
            x_r_q <= in_r;
            x_i_q <= in_i;
            v_q   <= in_valid;
            k     <= k_nxt;

            if (clr_sr) begin
                sr_r[0] <= '0;
                sr_r[1] <= '0;
                sr_i[0] <= '0;
                sr_i[1] <= '0;
            end else if (shift) begin
                sr_r[0] <= sr_r[1];
                sr_i[0] <= sr_i[1];
                sr_r[1] <= push_r;
                sr_i[1] <= push_i;
            end

            out_valid <= emit;
            out_r     <= emit ? emit_r : '0;
            out_i     <= emit ? emit_i : '0;

            if (state == IDLE) begin
                idx_cnt <= '0;
                out_idx <= '0;
            end else if (emit) begin
                out_idx <= idx_cnt;
                idx_cnt <= idx_cnt + 5'd1;
            end

            if (set_err) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fft_sdf_stage4.sv
// Directed bench for fft_sdf_stage4: group timing, ramp frames, extremes, stalls,
// the protocol-error path and reset mid-operation.
module tb_fft_sdf_stage4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_r = '0;
    logic [15:0] in_i = '0;
    logic        out_valid;
    logic [16:0] out_r;
    logic [16:0] out_i;
    logic [4:0]  out_idx;
    logic        err;

    int checks = 0;
    int errors = 0;

    fft_sdf_stage4 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_r      (in_r),
        .in_i      (in_i),
        .out_valid (out_valid),
        .out_r     (out_r),
        .out_i     (out_i),
        .out_idx   (out_idx),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        in_r     = '0;
        in_i     = '0;
        repeat (n) cyc();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_cycles(3);
        checks++;
        if (out_valid !== 1'b0 || out_r !== 17'd0 || out_i !== 17'd0 ||
            out_idx !== 5'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got valid=%0b r=%0d i=%0d idx=%0d err=%0b, want all 0",
                     out_valid, $signed(out_r), $signed(out_i), out_idx, err);
        end
        rst = 1'b0;
        cyc();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got valid=%0b want 0", out_valid);
        end
    endtask

    task automatic test_single_group(input string tag);
        int sr[4], si[4], er[4], ei[4];
        logic exp_v;
        sr = '{100, 0, 30, 0};
        si = '{0, 200, 0, 50};
        er = '{130, 0, 70, 150};
        ei = '{0, 250, 0, 0};
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 4);
            in_r     = (c < 4) ? 16'(sr[c]) : 16'd0;
            in_i     = (c < 4) ? 16'(si[c]) : 16'd0;
            exp_v    = (c >= 4 && c < 8);
            checks++;
            if (out_valid !== exp_v) begin
                errors++;
                $display("FAIL %s valid@%0d: got %0b want %0b", tag, c, out_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (out_r !== 17'(er[c-4]) || out_i !== 17'(ei[c-4]) || out_idx !== 5'(c-4)) begin
                    errors++;
                    $display("FAIL %s out@%0d: got (%0d,%0d) idx=%0d want (%0d,%0d) idx=%0d", tag, c,
                             $signed(out_r), $signed(out_i), out_idx, er[c-4], ei[c-4], c-4);
                end
            end
            if (c >= 8) begin
                checks++;
                if (out_idx !== 5'd0 || out_r !== 17'd0 || err !== 1'b0) begin
                    errors++;
                    $display("FAIL %s idle@%0d: got idx=%0d r=%0d err=%0b want 0,0,0", tag, c,
                             out_idx, $signed(out_r), err);
                end
            end
            cyc();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back;
        int j, g, pos, exp_r, exp_i;
        logic exp_v;
        for (int c = 0; c < 72; c++) begin
            in_valid = (c < 64);
            in_r     = (c < 64) ? 16'(c % 32) : 16'd0;
            in_i     = (c < 64) ? 16'(-(c % 32)) : 16'd0;
            exp_v    = (c >= 4 && c < 68);
            checks++;
            if (out_valid !== exp_v) begin
                errors++;
                $display("FAIL b2b valid@%0d: got %0b want %0b", c, out_valid, exp_v);
            end
            if (exp_v) begin
                j   = c - 4;
                g   = (j % 32) / 4;
                pos = j % 4;
                case (pos)
                    0: begin exp_r = 8*g + 2; exp_i = -(8*g + 2); end
                    1: begin exp_r = 8*g + 4; exp_i = -(8*g + 4); end
                    2: begin exp_r = -2;      exp_i = 2;          end
                    default: begin exp_r = 2; exp_i = 2;          end
                endcase
                checks++;
                if (out_r !== 17'(exp_r) || out_i !== 17'(exp_i) || out_idx !== 5'(j)) begin
                    errors++;
                    $display("FAIL b2b out@%0d: got (%0d,%0d) idx=%0d want (%0d,%0d) idx=%0d", c,
                             $signed(out_r), $signed(out_i), out_idx, exp_r, exp_i, j % 32);
                end
            end
            cyc();
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL b2b err: got %0b want 0", err);
        end
        idle_cycles(2);
    endtask

    task automatic test_extremes;
        int sr[4], si[4], er[4], ei[4];
        logic exp_v;
        sr = '{32767, 32767, -32768, -32768};
        si = '{-32768, -32768, 32767, 32767};
        er = '{-1, -1, 65535, -65535};
        ei = '{-1, -1, -65535, -65535};
        for (int c = 0; c < 10; c++) begin
            in_valid = (c < 4);
            in_r     = (c < 4) ? 16'(sr[c]) : 16'd0;
            in_i     = (c < 4) ? 16'(si[c]) : 16'd0;
            exp_v    = (c >= 4 && c < 8);
            checks++;
            if (out_valid !== exp_v) begin
                errors++;
                $display("FAIL extremes valid@%0d: got %0b want %0b", c, out_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (out_r !== 17'(er[c-4]) || out_i !== 17'(ei[c-4])) begin
                    errors++;
                    $display("FAIL extremes out@%0d: got (%0d,%0d) want (%0d,%0d)", c,
                             $signed(out_r), $signed(out_i), er[c-4], ei[c-4]);
                end
            end
            cyc();
        end
        idle_cycles(2);
    endtask

    task automatic test_stall;
        int sr[4], si[4], er[4], ei[4], at[4];
        int s;
        logic exp_v;
        sr = '{100, 0, 30, 0};
        si = '{0, 200, 0, 50};
        er = '{130, 0, 70, 150};
        ei = '{0, 250, 0, 0};
        at = '{0, 1, 5, 6};
        for (int c = 0; c < 16; c++) begin
            s = -1;
            for (int n = 0; n < 4; n++) if (at[n] == c) s = n;
            in_valid = (s >= 0);
            in_r     = (s >= 0) ? 16'(sr[s]) : 16'd0;
            in_i     = (s >= 0) ? 16'(si[s]) : 16'd0;
            exp_v    = (c >= 7 && c < 11);
            checks++;
            if (out_valid !== exp_v) begin
                errors++;
                $display("FAIL stall valid@%0d: got %0b want %0b", c, out_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (out_r !== 17'(er[c-7]) || out_i !== 17'(ei[c-7]) || out_idx !== 5'(c-7)) begin
                    errors++;
                    $display("FAIL stall out@%0d: got (%0d,%0d) idx=%0d want (%0d,%0d) idx=%0d", c,
                             $signed(out_r), $signed(out_i), out_idx, er[c-7], ei[c-7], c-7);
                end
            end
            cyc();
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL stall err: got %0b want 0", err);
        end
        idle_cycles(2);
    endtask

    task automatic test_protocol_error;
        int sr[5], si[5], er[4], ei[4];
        logic exp_v, exp_e;
        sr = '{100, 0, 30, 0, 5};
        si = '{0, 200, 0, 50, 5};
        er = '{130, 0, 70, 150};
        ei = '{0, 250, 0, 0};
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 5);
            in_r     = (c < 5) ? 16'(sr[c]) : 16'd0;
            in_i     = (c < 5) ? 16'(si[c]) : 16'd0;
            exp_v    = (c >= 4 && c < 8);
            exp_e    = (c >= 7);
            checks++;
            if (out_valid !== exp_v || err !== exp_e) begin
                errors++;
                $display("FAIL proto_err valid/err@%0d: got %0b/%0b want %0b/%0b", c,
                         out_valid, err, exp_v, exp_e);
            end
            if (exp_v) begin
                checks++;
                if (out_r !== 17'(er[c-4]) || out_i !== 17'(ei[c-4]) || out_idx !== 5'(c-4)) begin
                    errors++;
                    $display("FAIL proto_err out@%0d: got (%0d,%0d) idx=%0d want (%0d,%0d) idx=%0d", c,
                             $signed(out_r), $signed(out_i), out_idx, er[c-4], ei[c-4], c-4);
                end
            end
            if (c >= 8) begin
                checks++;
                if (out_idx !== 5'd0) begin
                    errors++;
                    $display("FAIL proto_err idle_idx@%0d: got %0d want 0", c, out_idx);
                end
            end
            cyc();
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL proto_err clear: got err=%0b want 0", err);
        end
    endtask

    task automatic test_mid_reset;
        int sr[4], si[4];
        sr = '{100, 0, 30, 0};
        si = '{0, 200, 0, 50};
        for (int c = 0; c < 11; c++) begin
            in_valid = (c < 4);
            in_r     = (c < 4) ? 16'(sr[c]) : 16'd0;
            in_i     = (c < 4) ? 16'(si[c]) : 16'd0;
            rst      = (c == 5);
            if (c == 4 || c == 5) begin
                checks++;
                if (out_valid !== 1'b1 || out_r !== ((c == 4) ? 17'd130 : 17'd0) ||
                    out_i !== ((c == 4) ? 17'd0 : 17'd250)) begin
                    errors++;
                    $display("FAIL mid_reset pre@%0d: got v=%0b (%0d,%0d) want v=1 sum%0d", c,
                             out_valid, $signed(out_r), $signed(out_i), c - 4);
                end
            end
            if (c >= 6) begin
                checks++;
                if (out_valid !== 1'b0 || out_r !== 17'd0 || out_i !== 17'd0 ||
                    out_idx !== 5'd0 || err !== 1'b0) begin
                    errors++;
                    $display("FAIL mid_reset post@%0d: got v=%0b r=%0d i=%0d idx=%0d err=%0b want all 0",
                             c, out_valid, $signed(out_r), $signed(out_i), out_idx, err);
                end
            end
            cyc();
        end
        rst = 1'b0;
        idle_cycles(2);
        test_single_group("after_reset");
    endtask

    initial begin
        test_reset();
        test_single_group("single");
        test_back_to_back();
        test_extremes();
        test_stall();
        test_protocol_error();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
